mips_registers: RTL and testbench

//  - MIPS general-purpose register file: 32 x 32-bit registers, two combinational read ports, one synchronous write port.
//  - Sits beside the R-type ALU in mips_core.
//  - Read ports supply rs/rt operands; the write port commits the ALU result to rd.
//  - Register $0 is hardwired to zero.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/mips_registers.sv | 46 ++++
 tb/tb_mips_registers.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS register file.
//   DATA_W    - width of each register and of the data ports
//   ADDR_W    - register index width
//   NUM_REGS  - number of architectural registers (2**ADDR_W)
//   REG_ZERO  - index of the hardwired-zero register $0
//   reg_idx_t - register index type
//   word_t    - one register word
//   reg_file_t - the whole register array, packed so it can be handed to a function
//   read_mux  - read-port selector shared by both read ports; $0 always yields zero
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0]                reg_idx_t;
  typedef logic [DATA_W-1:0]                word_t;
  typedef logic [NUM_REGS-1:0][DATA_W-1:0]  reg_file_t;

  localparam reg_idx_t REG_ZERO = '0;

  // The zero test is done here rather than relying on regs[0] holding zero,
  // so $0 reads 0 even before the first reset has been applied.
  function automatic word_t read_mux(input reg_file_t rf, input reg_idx_t idx);
    word_t result;
    if (idx == REG_ZERO) begin
      result = '0;
    end else begin
      result = rf[idx];
    end
    return result;
  endfunction

endpackage

// File: rtl/mips_registers.sv
// mips_registers: 32 x 32-bit MIPS general-purpose register file.
//   Two combinational read ports (rs / rt operands) and one synchronous
//   write port (rd result). Register $0 is hardwired to zero.
// Ports:
//   clk               in   1       clock; writes occur on its rising edge
//   rst               in   1       asynchronous active-high reset, clears all registers
//   read_data_1       out  DATA_W  contents of register read_reg_1
//   read_data_2       out  DATA_W  contents of register read_reg_2
//   write_data        in   DATA_W  data stored into write_reg
//   read_reg_1        in   ADDR_W  rs index
//   read_reg_2        in   ADDR_W  rt index
//   write_reg         in   ADDR_W  rd index
//   signal_reg_write  in   1       write enable, sampled at posedge clk
module mips_registers
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic              signal_reg_write
);

  reg_file_t regs;

  // Whole-array asynchronous clear; reset has priority, so a write that
  // coincides with reset is dropped. Writes to $0 are discarded here, and
  // the read mux also forces $0 to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (signal_reg_write && (write_reg != REG_ZERO)) begin
      regs[write_reg] <= write_data;
    end
  end

  // No write-to-read bypass: a same-cycle read returns the old value until
  // the clock edge commits the write.
  assign read_data_1 = read_mux(regs, read_reg_1);
  assign read_data_2 = read_mux(regs, read_reg_2);

endmodule

// File: tb/tb_mips_registers.sv
// tb_mips_registers: directed self-checking bench for mips_registers.
//   Expected read values are pushed onto a scoreboard queue when the read
//   indices are driven and popped and compared once the outputs settle.
module tb_mips_registers;
  import mips_pkg::*;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [ADDR_W-1:0] write_reg;
  logic              signal_reg_write;

  mips_registers dut (
    .clk              (clk),
    .rst              (rst),
    .read_data_1      (read_data_1),
    .read_data_2      (read_data_2),
    .write_data       (write_data),
    .read_reg_1       (read_reg_1),
    .read_reg_2       (read_reg_2),
    .write_reg        (write_reg),
    .signal_reg_write (signal_reg_write)
  );

  // Period 100: posedges at 50, 150, ...; negedges at 100, 200, ...
  initial clk = 1'b0;
  always #50 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Bench-side model of the architectural register contents.
  logic [DATA_W-1:0] model [NUM_REGS];

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] exp;
  } sb_t;
  sb_t sb[$];

  task automatic compare(input string port, input logic [DATA_W-1:0] obs);
    sb_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %h but scoreboard empty", port, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s.%s: observed %h expected %h", e.tag, port, obs, e.exp);
      end
    end
  endtask

  // Drive both read indices, queue the expectations, let the combinational
  // outputs settle, then compare.
  task automatic check_ports(input string tag,
                             input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                             input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
    sb_t a;
    sb_t b;
    read_reg_1 = r1;
    read_reg_2 = r2;
    a.tag = tag; a.exp = e1;
    b.tag = tag; b.exp = e2;
    sb.push_back(a);
    sb.push_back(b);
    #1;
    compare("p1", read_data_1);
    compare("p2", read_data_2);
  endtask

  // One write cycle: inputs change on the negedge, commit on the posedge.
  task automatic do_write(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] data,
                          input logic en);
    @(negedge clk);
    write_reg        = idx;
    write_data       = data;
    signal_reg_write = en;
    @(posedge clk);
    if (en && (idx != REG_ZERO)) model[idx] = data;
    #1;
    signal_reg_write = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    write_data       = '0;
    read_reg_1       = '0;
    read_reg_2       = '0;
    write_reg        = '0;
    signal_reg_write = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    #1;
    check_ports("reset_initial", 5'd5, 5'd31, 32'h0, 32'h0);

    // Write attempted while reset is held across a clock edge must be ignored.
    @(negedge clk);
    write_reg        = 5'd7;
    write_data       = 32'hCAFEF00D;
    signal_reg_write = 1'b1;
    @(posedge clk);
    #1;
    signal_reg_write = 1'b0;
    check_ports("write_during_reset", 5'd7, 5'd7, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write/read and independence of registers.
    do_write(5'd5, 32'hDEADBEEF, 1'b1);
    check_ports("r5_written", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    do_write(5'd31, 32'h00000007, 1'b1);
    check_ports("r5_r31", 5'd5, 5'd31, 32'hDEADBEEF, 32'h00000007);

    // $0 ignores writes.
    do_write(5'd0, 32'hFFFFFFFF, 1'b1);
    check_ports("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);

    // Enable low leaves state unchanged.
    do_write(5'd9, 32'h12345678, 1'b1);
    do_write(5'd9, 32'hAAAAAAAA, 1'b0);
    check_ports("enable_low", 5'd9, 5'd9, 32'h12345678, 32'h12345678);

    // Read-during-write: old value before the edge, new value right after.
    do_write(5'd3, 32'h1, 1'b1);
    @(negedge clk);
    write_reg        = 5'd3;
    write_data       = 32'h2;
    signal_reg_write = 1'b1;
    check_ports("rdw_before", 5'd3, 5'd9, 32'h1, 32'h12345678);
    @(posedge clk);
    model[3] = 32'h2;
    check_ports("rdw_after", 5'd3, 5'd3, 32'h2, 32'h2);
    signal_reg_write = 1'b0;

    // Both ports on the same register.
    do_write(5'd12, 32'h80000000, 1'b1);
    check_ports("dual_same_12", 5'd12, 5'd12, 32'h80000000, 32'h80000000);

    // Sweep: distinct pattern per index (r0 write is discarded).
    for (int i = 0; i < NUM_REGS; i++) begin
      do_write(ADDR_W'(i), DATA_W'(i) * 32'h01010101, 1'b1);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      check_ports($sformatf("sweep_pair_%0d", i), ADDR_W'(i), ADDR_W'(NUM_REGS - 1 - i),
                  model[i], model[NUM_REGS - 1 - i]);
      check_ports($sformatf("sweep_same_%0d", i), ADDR_W'(i), ADDR_W'(i),
                  model[i], model[i]);
    end

    // Mid-cycle reset pulse with a coincident write: everything clears with
    // no clock edge, and the write is lost.
    @(negedge clk);
    #5;
    write_reg        = 5'd20;
    write_data       = 32'h55AA55AA;
    signal_reg_write = 1'b1;
    rst              = 1'b1;
    #5;
    rst              = 1'b0;
    signal_reg_write = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      check_ports($sformatf("midreset_%0d", i), ADDR_W'(i), ADDR_W'(i), model[i], model[i]);
    end

    // Register file usable again after reset.
    do_write(5'd20, 32'h0BADF00D, 1'b1);
    check_ports("post_reset_write", 5'd20, 5'd5, 32'h0BADF00D, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
